// File: rtl/layer_mem_arb_pkg.sv
// Shared types for layer_mem_arbiter: arbiter states and read-return owner tags.
package layer_mem_arb_pkg;

    // State names carry an S_ prefix so they do not collide with the owner tags.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_C = 2'd1,
        S_OWN_H = 2'd2,
        S_TURN  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_H    = 2'd2
    } owner_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// RD_LAT-deep shift register of read-owner tags, aligned with the RAM read latency.
module rd_tag_pipe
    import layer_mem_arb_pkg::*;
#(
    parameter int unsigned RD_LAT = 2
) (
    input  logic   Clk,
    input  logic   Reset_n,
    input  owner_t tag_i,
    output owner_t tag_o
);

    owner_t pipe_q [RD_LAT];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= OWN_NONE;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/layer_mem_arbiter.sv
// Single-port RAM arbiter: compute (C) priority over host (H), tagged read return.
// Optional host starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module layer_mem_arbiter
    import layer_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              c_req,
    input  logic [ADDR_W-1:0] c_addr,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (RD_LAT < 1 || STARVE_MAX < 1) begin : g_bad_param
        $error("layer_mem_arbiter: RD_LAT and STARVE_MAX must be at least 1");
    end

    arb_state_t state_q, state_d;
    owner_t     next_own_q, next_own_d;
    owner_t     tag_push, tag_out;
    logic       starve_hit;

    // Grants and RAM drive are combinational from the registered owner.
    always_comb begin
        c_gnt = 1'b0;
        h_gnt = 1'b0;
        if (Reset_n) begin
            case (state_q)
                S_OWN_C: c_gnt = c_req;
                S_OWN_H: h_gnt = h_req;
                default: ;
            endcase
        end
        mem_addr  = c_gnt ? c_addr : (h_gnt ? h_addr : '0);
        mem_we    = h_gnt & h_we;
        mem_wdata = h_gnt ? h_wdata : '0;
        tag_push  = c_gnt ? OWN_C : ((h_gnt && !h_we) ? OWN_H : OWN_NONE);
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (!h_req || h_gnt) begin
            starve_d = '0;
        end else if (c_gnt && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end
        // Hand over on the grant that brings the count to STARVE_MAX.
        starve_hit = c_gnt && h_req && (starve_q >= SW'(STARVE_MAX - 1));
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) starve_q <= '0;
        else          starve_q <= starve_d;
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        next_own_d = next_own_q;
        case (state_q)
            S_IDLE: begin
                if (c_req)      state_d = S_OWN_C;
                else if (h_req) state_d = S_OWN_H;
            end
            S_OWN_C: begin
                if (h_req && (!c_req || starve_hit)) begin
                    state_d    = S_TURN;
                    next_own_d = OWN_H;
                end else if (!c_req) begin
                    state_d = S_IDLE;
                end
            end
            S_OWN_H: begin
                if (c_req) begin
                    state_d    = S_TURN;
                    next_own_d = OWN_C;
                end else if (!h_req) begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                if (next_own_q == OWN_C) begin
                    if (c_req)      state_d = S_OWN_C;
                    else if (h_req) state_d = S_OWN_H;
                    else            state_d = S_IDLE;
                end else begin
                    if (h_req)      state_d = S_OWN_H;
                    else if (c_req) state_d = S_OWN_C;
                    else            state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            next_own_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            next_own_q <= next_own_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .tag_i   (tag_push),
        .tag_o   (tag_out)
    );

    assign c_rvalid = Reset_n && (tag_out == OWN_C);
    assign h_rvalid = Reset_n && (tag_out == OWN_H);
    assign c_rdata  = c_rvalid ? mem_rdata : '0;
    assign h_rdata  = h_rvalid ? mem_rdata : '0;

endmodule

// File: doc/layer_mem_arbiter.md
# layer_mem_arbiter

Arbitrates the single-port on-chip weight/activation RAM between two requesters. The compute side (C) is the layer sequencer's MAC feed, issuing streaming reads. The host side (H) is the image/weight loader, issuing reads and writes. Sits between both requesters and the RAM, and routes read data back to the issuer through a latency-matched tag pipeline. Compute has priority; an optional starvation guard bounds host wait time.

## Interface
Parameters:
- ADDR_W, 10, RAM address width
- DATA_W, 16, RAM data width
- RD_LAT, 2, RAM read latency in cycles (≥1)
- STARVE_MAX, 8, consecutive C grants allowed while h_req pending (guard only)

Ports:
- Clk  in  1  clock; all logic on posedge
- Reset_n  in  1  synchronous, active-low reset
- c_req  in  1  compute access request (read only)
- c_addr  in  ADDR_W  compute address
- c_gnt  out  1  compute access issued this cycle
- c_rvalid  out  1  c_rdata valid
- c_rdata  out  DATA_W  compute read data
- h_req  in  1  host access request
- h_we  in  1  host write enable (1 = write, 0 = read)
- h_addr  in  ADDR_W  host address
- h_wdata  in  DATA_W  host write data
- h_gnt  out  1  host access issued this cycle
- h_rvalid  out  1  h_rdata valid
- h_rdata  out  DATA_W  host read data
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, RD_LAT cycles after the address

## Operation
- States: IDLE, OWN_C, OWN_H, TURN. The state is registered; grants are combinational from the state and the request.
- IDLE:
  - If c_req → OWN_C.
  - Else if h_req → OWN_H.
  - No grants are issued in IDLE.
- OWN_C:
  - c_gnt = c_req. mem_addr = c_addr, mem_we = 0.
  - c_req low and h_req high → TURN (next owner H).
  - Both low → IDLE.
  - Starvation trigger (guard only) → TURN (next owner H).
- OWN_H:
  - h_gnt = h_req. mem_addr = h_addr, mem_we = h_we, mem_wdata = h_wdata.
  - If c_req is high during an H grant, the host gets exactly that one beat, then → TURN (next owner C).
  - h_req low → TURN (next owner C) if c_req is high, else IDLE.
- TURN:
  - One dead cycle: no grant, mem_we = 0.
  - Then → the latched next owner if that requester is still requesting.
  - Otherwise → the other owner if it is requesting, else IDLE.
- No grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Tag pipeline:
  - Each granted read pushes a 2-bit tag {NONE, C, H}; ungranted cycles and writes push NONE.
  - The tag emerges RD_LAT cycles later. c_rvalid/h_rvalid are decoded from it; the matching rdata = mem_rdata, the other rdata = 0.
- Starve counter (guard only):
  - Increments on each c_gnt while h_req is high.
  - Clears on h_gnt or when h_req is low.
  - Saturates at STARVE_MAX.
  - A value of STARVE_MAX forces OWN_C → TURN → OWN_H after the current grant.

## Timing
- Reset (Reset_n low at posedge): state IDLE, starve count 0, tag pipe all NONE.
- All outputs are 0 during reset and the cycle after: c_gnt, h_gnt, c_rvalid, h_rvalid, c_rdata, h_rdata, mem_addr, mem_we, mem_wdata.
- Grant latency:
  - From IDLE, a request sampled at cycle n is granted at cycle n+1.
  - An owner switch costs exactly 1 TURN cycle.
- Read data: rvalid is high exactly RD_LAT cycles after the grant cycle, one beat per grant, in order.
- Handshake: requester address/data must be stable while req is high. An access completes only in a cycle with gnt high; the requester holds req until it sees gnt.
- Simultaneous c_req and h_req in IDLE: C wins.
- Reset mid-operation: in-flight tags are discarded; no rvalid is produced for pre-reset grants.
- Host writes never produce rvalid.

## Configuration
- ARB_STARVE_GUARD_EN defined: starve counter present; host is guaranteed one beat after at most STARVE_MAX consecutive C grants.
- ARB_STARVE_GUARD_EN undefined: counter removed; strict compute priority; host waits indefinitely while c_req stays high.

## Structure
- Package layer_mem_arb_pkg: arb_state_t enum (IDLE, OWN_C, OWN_H, TURN) and owner_t tag enum (OWN_NONE, OWN_C, OWN_H).
- Sub-module rd_tag_pipe: RD_LAT-deep shift register of owner_t with synchronous active-low clear; outputs the emerging tag.

## Test plan
- Reset_n low for 2 cycles with c_req = h_req = 1 → all outputs 0 throughout; the first c_gnt is 1 cycle after Reset_n rises.
- c_req only, c_addr = 5, RAM returns 0xABCD for address 5 → c_gnt at cycle 1; c_rvalid = 1 with c_rdata = 0xABCD at cycle 3; h_rvalid stays 0.
- From IDLE: h_req = 1, h_we = 1, h_addr = 0x3FF, h_wdata = 0x1234 → in the grant cycle mem_we = 1, mem_addr = 0x3FF, mem_wdata = 0x1234; no rvalid follows.
- c_req and h_req held continuously, STARVE_MAX = 8:
  - Guard on → 8 c_gnt, 1 TURN, 1 h_gnt, 1 TURN, c_gnt resumes; the pattern repeats.
  - Guard off → h_gnt is never asserted.
- C read granted, Reset_n low in the next cycle → neither c_rvalid nor h_rvalid is asserted afterwards.
- c_req drops while h_req is held → exactly 1 TURN cycle, then h_gnt every cycle; host read data returns RD_LAT cycles after each grant.
